oam_dma_engine: RTL and testbench

Parametrised page-to-OAM DMA engine: a CPU write to a trigger address halts the CPU and copies `LEN` consecutive bytes from a source page into sprite OAM. It sits between the CPU bus arbiter and the PPU OAM write port. Unlike the earlier trigger-and-address generator, it:
- captures the read data itself and drives OAM write data;
- applies a programmable OAM base offset with wrap-around;
- signals completion;
- can optionally insert an odd-cycle alignment stall.

---
 rtl/oam_dma_engine.sv | 139 +++++++++++++
 tb/tb_oam_dma_engine.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_engine.sv
// Page-to-OAM DMA: a CPU write to TRIG_ADDR halts the CPU and copies LEN bytes from a page into OAM.
// Optional odd-cycle alignment stall is enabled by defining OAM_DMA_ALIGN_EN.
module oam_dma_engine #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] TRIG_ADDR = 16'h4014,
  parameter int                LEN       = 256,
  parameter int                DST_AW    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_wr,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic [DST_AW-1:0] oam_base,
  output logic              halt,
  output logic              hijack,
  output logic [ADDR_W-1:0] out_bus_addr,
  output logic [DST_AW-1:0] oam_addr,
  output logic [DATA_W-1:0] oam_wdata,
  output logic              oam_en,
  output logic              done
);

  typedef enum logic [2:0] {
    IDL  = 3'd0,
    HALT = 3'd1,
`ifdef OAM_DMA_ALIGN_EN
    ALGN = 3'd2,
`endif
    RD   = 3'd3,
    WR   = 3'd4
  } state_t;

  localparam logic [7:0] LAST = 8'(LEN - 1);

  state_t            state_reg;
  logic [7:0]        ctr_reg;
  logic [DATA_W-1:0] page_reg;
  logic [DST_AW-1:0] base_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              halt_reg;
  logic              hijack_reg;
  logic              oam_en_reg;
  logic              done_reg;

  wire trig = (bus_addr == TRIG_ADDR) && !bus_wr;

`ifdef OAM_DMA_ALIGN_EN
  logic phase_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) phase_reg <= 1'b0;
    else          phase_reg <= ~phase_reg;
  end
`endif

  // Outputs are registered alongside the state so they follow the state without a decode delay.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDL;
      ctr_reg    <= 8'd0;
      page_reg   <= '0;
      base_reg   <= '0;
      rdata_reg  <= '0;
      halt_reg   <= 1'b0;
      hijack_reg <= 1'b0;
      oam_en_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDL: begin
          if (trig) begin
            state_reg <= HALT;
            page_reg  <= bus_wdata;
            base_reg  <= oam_base;
            halt_reg  <= 1'b1;
          end
        end
        HALT: begin
`ifdef OAM_DMA_ALIGN_EN
          if (phase_reg) begin
            state_reg <= ALGN;
          end else begin
            state_reg  <= RD;
            ctr_reg    <= 8'd0;
            hijack_reg <= 1'b1;
          end
`else
          state_reg  <= RD;
          ctr_reg    <= 8'd0;
          hijack_reg <= 1'b1;
`endif
        end
`ifdef OAM_DMA_ALIGN_EN
        ALGN: begin
          state_reg  <= RD;
          ctr_reg    <= 8'd0;
          hijack_reg <= 1'b1;
        end
`endif
        RD: begin
          state_reg  <= WR;
          rdata_reg  <= bus_rdata;
          oam_en_reg <= 1'b1;
        end
        WR: begin
          oam_en_reg <= 1'b0;
          if (ctr_reg == LAST) begin
            state_reg  <= IDL;
            halt_reg   <= 1'b0;
            hijack_reg <= 1'b0;
            done_reg   <= 1'b1;
          end else begin
            state_reg <= RD;
            ctr_reg   <= ctr_reg + 8'd1;
          end
        end
        default: begin
          state_reg  <= IDL;
          halt_reg   <= 1'b0;
          hijack_reg <= 1'b0;
          oam_en_reg <= 1'b0;
        end
      endcase
    end
  end

  assign halt         = halt_reg;
  assign hijack       = hijack_reg;
  assign oam_en       = oam_en_reg;
  assign done         = done_reg;
  assign oam_wdata    = rdata_reg;
  assign out_bus_addr = {page_reg, ctr_reg};
  assign oam_addr     = base_reg + DST_AW'(ctr_reg);

endmodule

// File: tb/tb_oam_dma_engine.sv
// Randomized bench for oam_dma_engine (LEN=256): a byte-level reference of the source page and
// the expected OAM write sequence is checked for every transfer, plus reset and trigger corner cases.
module tb_oam_dma_engine;

  localparam int LEN = 256;

  logic        clk;
  logic        reset_n;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_wr;
  logic [7:0]  bus_rdata;
  logic [7:0]  oam_base;
  logic        halt;
  logic        hijack;
  logic [15:0] out_bus_addr;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_en;
  logic        done;

  logic [7:0]  key_reg;
  logic [7:0]  noise;
  logic        tb_phase;

  int n_cmp = 0;
  int n_err = 0;

  oam_dma_engine #(
    .DATA_W(8), .ADDR_W(16), .TRIG_ADDR(16'h4014), .LEN(LEN), .DST_AW(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wr(bus_wr), .bus_rdata(bus_rdata), .oam_base(oam_base), .halt(halt),
    .hijack(hijack), .out_bus_addr(out_bus_addr), .oam_addr(oam_addr),
    .oam_wdata(oam_wdata), .oam_en(oam_en), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source memory: byte at address A is A[7:0] ^ key; valid only while the engine reads.
  assign bus_rdata = (hijack && !oam_en) ? (out_bus_addr[7:0] ^ key_reg) : noise;

  // Phase reference: 0 out of reset, flips on every clock.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_phase <= 1'b0;
    else          tb_phase <= ~tb_phase;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus_addr  = {2'b00, 14'($urandom)};
    bus_wr    = 1'($urandom);
    bus_wdata = 8'($urandom);
    oam_base  = 8'($urandom);
    noise     = 8'($urandom);
  endtask

  task automatic drive_trig(input logic [7:0] page, input logic [7:0] base);
    bus_addr  = 16'h4014;
    bus_wr    = 1'b0;
    bus_wdata = page;
    oam_base  = base;
    noise     = 8'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_halt"},   32'(halt),         32'd0);
    check_eq({tag, "_hijack"}, 32'(hijack),       32'd0);
    check_eq({tag, "_oam_en"}, 32'(oam_en),       32'd0);
    check_eq({tag, "_done"},   32'(done),         32'd0);
    check_eq({tag, "_baddr"},  32'(out_bus_addr), 32'd0);
    check_eq({tag, "_oaddr"},  32'(oam_addr),     32'd0);
    check_eq({tag, "_wdata"},  32'(oam_wdata),    32'd0);
  endtask

  // Called at a negedge in which the trigger write is already being driven (state IDL).
  task automatic xfer(input logic [7:0] page, input logic [7:0] base, input logic [7:0] key,
                      input int retrig, input bit chain,
                      input logic [7:0] npage, input logic [7:0] nbase);
    int hl, widx, exp_len;
    bit rt;
    logic [7:0] exp_oaddr;
    hl = 0; widx = 0; rt = 1'b0;
    key_reg = key;
    @(negedge clk);
    drive_idle();
    exp_len = 1 + 2 * LEN;
`ifdef OAM_DMA_ALIGN_EN
    exp_len += int'(tb_phase);
`endif
    while (halt && hl < 2000) begin
      hl++;
      if (oam_en) begin
        exp_oaddr = base + 8'(widx);
        check_eq("src_addr", 32'(out_bus_addr), 32'({page, 8'(widx)}));
        check_eq("oam_addr", 32'(oam_addr), 32'(exp_oaddr));
        check_eq("oam_data", 32'(oam_wdata), 32'(8'(widx) ^ key));
        check_eq("hijack_wr", 32'(hijack), 32'd1);
`ifdef OAM_DMA_ALIGN_EN
        check_eq("wr_phase", 32'(tb_phase), 32'd0);
`endif
        widx++;
      end
      check_eq("no_early_done", 32'(done), 32'd0);
      if (widx == retrig && !rt) begin
        drive_trig(8'h07, base ^ 8'h33);
        rt = 1'b1;
      end else begin
        drive_idle();
      end
      @(negedge clk);
    end
    check_eq("halt_len", 32'(hl), 32'(exp_len));
    check_eq("n_writes", 32'(widx), 32'(LEN));
    check_eq("done_pulse", 32'(done), 32'd1);
    $display("xfer page=%02h base=%02h key=%02h retrig=%0d halt_cycles=%0d writes=%0d",
             page, base, key, retrig, hl, widx);
    if (chain) begin
      drive_trig(npage, nbase);
    end else begin
      @(negedge clk);
      check_eq("done_low", 32'(done), 32'd0);
      check_eq("idle_halt", 32'(halt), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] p1, b1, p2, b2;
    int n;
    reset_n = 1'b0;
    key_reg = 8'h00;
    drive_idle();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("post_reset_halt", 32'(halt), 32'd0);

    // Full page copy, memory pattern = low address byte ^ 5A.
    drive_trig(8'h02, 8'h00);
    xfer(8'h02, 8'h00, 8'h5A, -1, 1'b0, 8'h00, 8'h00);

    // OAM base wrap.
    drive_trig(8'h03, 8'hFC);
    xfer(8'h03, 8'hFC, 8'($urandom), -1, 1'b0, 8'h00, 8'h00);

    // Retrigger mid-transfer is ignored.
    drive_trig(8'h02, 8'h10);
    xfer(8'h02, 8'h10, 8'($urandom), 100, 1'b0, 8'h00, 8'h00);

    // Read of the trigger address and write to a neighbour never start a transfer.
    bus_addr = 16'h4014; bus_wr = 1'b1; bus_wdata = 8'h09;
    @(negedge clk);
    check_eq("read_trig_halt", 32'(halt), 32'd0);
    bus_addr = 16'h4015; bus_wr = 1'b0;
    @(negedge clk);
    check_eq("wr4015_halt", 32'(halt), 32'd0);
    drive_idle();
    @(negedge clk);
    check_eq("nontrig_halt", 32'(halt), 32'd0);
    check_eq("nontrig_hijack", 32'(hijack), 32'd0);

    // Random transfers; the first of each pair is retriggered in its own done cycle.
    for (int i = 0; i < 2; i++) begin
      p1 = 8'($urandom); b1 = 8'($urandom);
      p2 = 8'($urandom); b2 = 8'($urandom);
      repeat ($urandom_range(0, 1)) @(negedge clk);
      drive_trig(p1, b1);
      xfer(p1, b1, 8'($urandom), -1, 1'b1, p2, b2);
      xfer(p2, b2, 8'($urandom), -1, 1'b0, 8'h00, 8'h00);
    end

    // Reset in the middle of a transfer, then a fresh transfer from byte 0.
    key_reg = 8'hC3;
    drive_trig(8'h44, 8'h20);
    @(negedge clk);
    drive_idle();
    n = 0;
    for (int c = 0; c < 1000 && n < 100; c++) begin
      if (oam_en) n++;
      @(negedge clk);
    end
    check_eq("reached_byte100", 32'(n), 32'd100);
    #2 reset_n = 1'b0;
    #1 check_all_zero("mid_reset");
    repeat (2) @(negedge clk);
    check_all_zero("held_reset");
    reset_n = 1'b1;
    @(negedge clk);
    drive_trig(8'h55, 8'hF0);
    xfer(8'h55, 8'hF0, 8'($urandom), -1, 1'b0, 8'h00, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
